// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode and FSM state encodings shared by the sequential ALU
// and the CPU decode stage, plus small opcode-classification helpers.
// Optional feature macro: ALU_MUL_EN (enables the iterative MUL opcode).
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_SLT  = 4'd3,
    OP_AND  = 4'd4,
    OP_NAND = 4'd5,
    OP_NOR  = 4'd6,
    OP_OR   = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // Variable shifts run one bit per cycle in the SHIFT state.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // MUL only exists when the multiplier is built in.
  function automatic logic is_mul(input logic [3:0] op);
    return MUL_EN && (op == OP_MUL);
  endfunction

endpackage

// File: rtl/seq_alu_addsub.sv
// seq_alu_addsub: combinational WIDTH-bit adder/subtractor shared by ADD,
// SUB and SLT. Subtraction is A + ~B + 1, so carry-out means "no borrow".
module seq_alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b_eff;

  assign w_b_eff = i_sub ? ~i_b : i_b;

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

  // Signed overflow: operands agree in sign, result disagrees.
  assign o_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with valid/ready handshakes, registered result/flags,
// one-bit-per-cycle variable shifts and, with ALU_MUL_EN defined, an
// iterative unsigned shift-add multiplier (WIDTH cycles).
// Optional feature macro: ALU_MUL_EN.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       command,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

  state_e           r_state;
  state_e           w_next;
  logic [3:0]       r_op;
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;

  logic             w_accept;
  logic [SHW-1:0]   w_amt;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_as_carry;
  logic             w_as_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_illegal;
  logic [WIDTH-1:0] w_shift_next;

  assign w_accept = in_valid && in_ready;
  assign w_amt    = operandB[SHW-1:0];
  assign w_sub    = (command == OP_SUB) || (command == OP_SLT);

  seq_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a     (operandA),
    .i_b     (operandB),
    .i_sub   (w_sub),
    .o_sum   (w_sum),
    .o_carry (w_as_carry),
    .o_ovf   (w_as_ovf)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default every comb output first so no path infers a latch.
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_mul(command))                        w_next = ST_MUL;
          else if (is_shift(command) && (w_amt != '0)) w_next = ST_SHIFT;
          else                                         w_next = ST_DONE;
        end
      end
      ST_SHIFT: if (r_cnt == CNT_ONE) w_next = ST_DONE;
      ST_MUL:   if (r_cnt == CNT_ONE) w_next = ST_DONE;
      ST_DONE:  if (out_ready)        w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs; in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: in_ready  = reset_n;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle result and flags, evaluated on the incoming command.
  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (command)
      OP_ADD, OP_SUB: begin
        w_res   = w_sum;
        w_carry = w_as_carry;
        w_ovf   = w_as_ovf;
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_as_ovf};
      OP_XOR:  w_res = operandA ^ operandB;
      OP_AND:  w_res = operandA & operandB;
      OP_NAND: w_res = ~(operandA & operandB);
      OP_NOR:  w_res = ~(operandA | operandB);
      OP_OR:   w_res = operandA | operandB;
      // Shifts start from A; a zero amount completes immediately with A.
      OP_SLL, OP_SRL, OP_SRA: w_res = operandA;
      OP_MUL:  w_illegal = ~MUL_EN;
      default: w_illegal = 1'b1;
    endcase
  end

  // One-bit shift of the working register for the in-flight shift op.
  always_comb begin
    w_shift_next = r_result;
    case (r_op)
      OP_SLL:  w_shift_next = {r_result[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shift_next = {1'b0, r_result[WIDTH-1:1]};
      OP_SRA:  w_shift_next = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_hi;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi_next;
  logic [WIDTH-1:0] w_mul_lo_next;

  // Shift-add step: {hi, lo} holds the partial product, lo starts as B.
  always_comb begin
    w_mul_sum     = {1'b0, r_mul_hi} + (r_result[0] ? {1'b0, r_mul_a} : '0);
    w_mul_hi_next = w_mul_sum[WIDTH:1];
    w_mul_lo_next = {w_mul_sum[0], r_result[WIDTH-1:1]};
  end

  // Multiplier operand and high-half registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mul_a  <= '0;
      r_mul_hi <= '0;
    end else if (r_state == ST_IDLE && w_accept) begin
      r_mul_a  <= operandA;
      r_mul_hi <= '0;
    end else if (r_state == ST_MUL) begin
      r_mul_hi <= w_mul_hi_next;
    end
  end
`endif

  // Datapath: latch on accept, iterate in SHIFT/MUL, hold in DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op      <= command;
            r_carry   <= w_carry;
            r_ovf     <= w_ovf;
            r_illegal <= w_illegal;
            if (is_mul(command)) begin
              r_cnt    <= CNT_MUL;
              r_result <= operandB;
              r_zero   <= 1'b0;
            end else begin
              r_cnt    <= {1'b0, w_amt};
              r_result <= w_res;
              r_zero   <= (w_res == '0);
            end
          end
        end
        ST_SHIFT: begin
          r_cnt    <= r_cnt - CNT_ONE;
          r_result <= w_shift_next;
          r_zero   <= (w_shift_next == '0);
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          r_cnt    <= r_cnt - CNT_ONE;
          r_result <= w_mul_lo_next;
          r_zero   <= (w_mul_lo_next == '0);
          r_ovf    <= (w_mul_hi_next != '0);
        end
`endif
        default: ;
      endcase
    end
  end

  assign result   = r_result;
  assign carryout = r_carry;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign illegal  = r_illegal;

endmodule
